matched_filter: RTL and testbench
=================================

// Module: matched_filter
// PURPOSE
//  Non-coherent 2-FSK/MSK demodulator for the SCuM low-IF receiver. Correlates the 16 MS/s
//  4-bit I/Q stream against quantized complex tones at the mode's two FSK frequencies.
//  Decides each symbol by comparing the tone energies. The decision is captured when the
//  timing-recovery block pulses update; one bit is produced per recovered symbol.
// PARAMETERS
//  W_IN    4   I/Q sample width, offset binary (8 = zero)
//  W_COEF  4   template coefficient width, signed, range -7..+7
//  N_MAX   16  delay-line depth (longest template, BLE)
//  W_OUT   8   mf_output width, signed
// PORTS
//  clk         in   1      16 MHz sample clock; one I/Q sample per rising edge
//  rst         in   1      asynchronous, active-low reset
//  select      in   2      mode: 0 BLE 2.0/2.5 MHz, 1 802.15.4 2.0/3.0 MHz,
//                          2 BLE 1.5/2.0 MHz, 3 BLE 1.0/1.5 MHz (low/high tone)
//  update      in   1      1-cycle strobe from timing recovery: capture decision
//  I_BPF       in   W_IN   in-phase sample from band-pass filter
//  Q_BPF       in   W_IN   quadrature sample from band-pass filter
//  MF_Output   out  W_OUT  signed soft metric (E_high - E_low), scaled and saturated
//  data        out  1      hard bit decision, held between update strobes
// BEHAVIOUR
//  - Reset: delay lines, pipeline registers, MF_Output=0, data=0; asynchronous assertion.
//  - Input stage: each clk, x = I_BPF-8 and y = Q_BPF-8 (signed, -8..+7) are registered.
//    Each is shifted into an N_MAX-deep delay line. There is no enable; every clk is a sample.
//  - Template length: N = 16 for modes 0, 2, 3 (1 Mb/s), N = 8 for mode 1 (2 Mchip/s).
//    Only the newest N taps are used.
//  - Coefficients: c_f[k] = round(7*cos(2*pi*f*k/16e6)) and s_f[k] = round(7*sin(...)),
//    with k=0 at the oldest tap. Stored as constant tables per mode and per tone.
//  - Correlation per tone f: Re = sum(x*c + y*s) and Im = sum(y*c - x*s).
//    Products are 8-bit signed; sums are 13-bit signed with no overflow possible.
//  - Energy: E_f = |Re| + |Im|, unsigned 13-bit. Exact |.| is required, including the
//    most-negative input.
//  - Decision: d = (E_high > E_low); a tie gives 0.
//  - Soft metric: MF_Output = sat8((E_high - E_low) >>> 4), arithmetic shift.
//  - Pipeline: input register -> correlation register -> energy/decision register.
//    A sample on the I/Q ports affects d and MF_Output 3 clk edges later. MF_Output
//    updates every clk.
//  - Output strobe: on a clk edge with update=1, data <= d; otherwise data holds. The new
//    value is visible the cycle after the strobe. A consumer sampling on the update edge
//    sees the previous bit. Back-to-back strobes are each honoured.
//  - Mode change: takes effect on the next clk. The delay line is not flushed; outputs are
//    meaningless for N+3 cycles.
//  - Reset mid-operation: all state clears immediately. The first valid decision comes
//    N+3 cycles after rst deasserts.
// TESTING
//  1 Reset: hold rst=0 and toggle all inputs -> MF_Output=0, data=0; release with
//    I=Q=8 -> both stay 0 (tie => 0).
//  2 Mode 0, 2.5 MHz tone (I=8+round(7cos), Q=8+round(7sin)), update every 16 clk ->
//    data=1 from the 2nd strobe on; MF_Output>0.
//  3 Mode 0, 2.0 MHz tone, same stimulus -> data=0; MF_Output<0.
//  4 Mode 1, alternating 8-sample bursts of 3.0/2.0 MHz tones, update at each burst end+3
//    -> data toggles 1,0,1,0.
//  5 Hold update=0 for 100 cycles while the tone flips -> data frozen; MF_Output
//    follows the tone.
//  6 Assert rst low for 1 cycle mid-stream in mode 3 -> data/MF_Output 0 at once; correct
//    bits resume after 19 cycles.

Source files
------------

// File: rtl/matched_filter_if.sv
// Signal bundle between the low-IF front end / timing recovery and the matched-filter demodulator.
interface matched_filter_if #(
    parameter int W_IN  = 4,
    parameter int W_OUT = 8
);
    // No valid/ready pair: I_BPF/Q_BPF carry one sample on every clk edge, update is a
    // one-cycle strobe, and data changes only on the edge that sees update=1, holding otherwise.
    logic [1:0]              select;
    logic                    update;
    logic [W_IN-1:0]         I_BPF;
    logic [W_IN-1:0]         Q_BPF;
    logic signed [W_OUT-1:0] MF_Output;
    logic                    data;

    modport master (output select, update, I_BPF, Q_BPF, input MF_Output, data);
    modport slave  (input select, update, I_BPF, Q_BPF, output MF_Output, data);
endinterface

// File: rtl/matched_filter.sv
// Non-coherent 2-FSK/MSK demodulator: correlates the I/Q stream against two quantized tones
// per mode, compares |Re|+|Im| energies and latches the bit on each timing-recovery strobe.
module matched_filter #(
    parameter int W_IN   = 4,
    parameter int W_COEF = 4,
    parameter int N_MAX  = 16,
    parameter int W_OUT  = 8
) (
    input  logic            clk,
    input  logic            rst,
    matched_filter_if.slave mf_bus
);
    localparam int W_PROD  = W_IN + W_COEF;
    localparam int W_ACC   = 13;
    localparam int OUT_MAX = 2 ** (W_OUT - 1) - 1;
    localparam int OUT_MIN = -(2 ** (W_OUT - 1));

    typedef logic signed [W_IN-1:0]   sample_t;
    typedef logic signed [W_COEF-1:0] coef_t;
    typedef logic signed [W_PROD-1:0] prod_t;
    typedef logic signed [W_ACC-1:0]  acc_t;
    typedef logic [W_ACC-1:0]         mag_t;
    typedef logic signed [W_ACC:0]    diff_t;
    typedef logic signed [W_OUT-1:0]  out_t;

    // round(7*cos(m*2*pi/32)); every tone is a multiple of 0.5 MHz, so all phases fall on this grid
    function automatic coef_t cos_lut(input logic [4:0] m);
        int v;
        case (m)
            5'd0, 5'd1, 5'd31:             v = 7;
            5'd2, 5'd3, 5'd29, 5'd30:      v = 6;
            5'd4, 5'd28:                   v = 5;
            5'd5, 5'd27:                   v = 4;
            5'd6, 5'd26:                   v = 3;
            5'd7, 5'd25:                   v = 1;
            5'd8, 5'd24:                   v = 0;
            5'd9, 5'd23:                   v = -1;
            5'd10, 5'd22:                  v = -3;
            5'd11, 5'd21:                  v = -4;
            5'd12, 5'd20:                  v = -5;
            5'd13, 5'd14, 5'd18, 5'd19:    v = -6;
            default:                       v = -7;
        endcase
        return coef_t'(v);
    endfunction

    // Phase advance per sample in 1/32-cycle units (f / 0.5 MHz)
    function automatic logic [2:0] tone_step(input logic [1:0] mode, input logic high);
        logic [2:0] s;
        case (mode)
            2'd0:    s = high ? 3'd5 : 3'd4;
            2'd1:    s = high ? 3'd6 : 3'd4;
            2'd2:    s = high ? 3'd4 : 3'd3;
            default: s = high ? 3'd3 : 3'd2;
        endcase
        return s;
    endfunction

    function automatic prod_t mul(input sample_t a, input coef_t b);
        return a * b;
    endfunction

    // Two's-complement negate into an unsigned field of the same width keeps -4096 exact
    function automatic mag_t mag(input acc_t v);
        return v[W_ACC-1] ? mag_t'(~v) + mag_t'(1) : mag_t'(v);
    endfunction

    sample_t x_q [N_MAX];
    sample_t y_q [N_MAX];
    coef_t   c_lo [N_MAX];
    coef_t   s_lo [N_MAX];
    coef_t   c_hi [N_MAX];
    coef_t   s_hi [N_MAX];

    acc_t re_lo_d, im_lo_d, re_hi_d, im_hi_d;
    acc_t re_lo_q, im_lo_q, re_hi_q, im_hi_q;
    mag_t e_lo, e_hi;
    diff_t diff, shifted;
    out_t mf_d, mf_q;
    logic dec_d, dec_q, data_q;

    // Tap 0 is the newest sample; k=0 sits on the oldest of the N taps in use
    always_comb begin
        int         taps;
        logic [2:0] st_lo;
        logic [2:0] st_hi;
        logic [4:0] k;
        logic [4:0] ph_lo;
        logic [4:0] ph_hi;
        taps  = (mf_bus.select == 2'd1) ? N_MAX / 2 : N_MAX;
        st_lo = tone_step(mf_bus.select, 1'b0);
        st_hi = tone_step(mf_bus.select, 1'b1);
        k     = '0;
        ph_lo = '0;
        ph_hi = '0;
        for (int j = 0; j < N_MAX; j++) begin
            c_lo[j] = '0;
            s_lo[j] = '0;
            c_hi[j] = '0;
            s_hi[j] = '0;
            if (j < taps) begin
                k       = 5'(taps - 1 - j);
                ph_lo   = 5'(k * 5'(st_lo));
                ph_hi   = 5'(k * 5'(st_hi));
                c_lo[j] = cos_lut(ph_lo);
                s_lo[j] = cos_lut(ph_lo + 5'd24);
                c_hi[j] = cos_lut(ph_hi);
                s_hi[j] = cos_lut(ph_hi + 5'd24);
            end
        end
    end

    always_comb begin
        re_lo_d = '0;
        im_lo_d = '0;
        re_hi_d = '0;
        im_hi_d = '0;
        for (int j = 0; j < N_MAX; j++) begin
            re_lo_d = re_lo_d + acc_t'(mul(x_q[j], c_lo[j])) + acc_t'(mul(y_q[j], s_lo[j]));
            im_lo_d = im_lo_d + acc_t'(mul(y_q[j], c_lo[j])) - acc_t'(mul(x_q[j], s_lo[j]));
            re_hi_d = re_hi_d + acc_t'(mul(x_q[j], c_hi[j])) + acc_t'(mul(y_q[j], s_hi[j]));
            im_hi_d = im_hi_d + acc_t'(mul(y_q[j], c_hi[j])) - acc_t'(mul(x_q[j], s_hi[j]));
        end
    end

    always_comb begin
        e_lo    = mag(re_lo_q) + mag(im_lo_q);
        e_hi    = mag(re_hi_q) + mag(im_hi_q);
        diff    = $signed({1'b0, e_hi}) - $signed({1'b0, e_lo});
        shifted = diff >>> 4;
        dec_d   = (e_hi > e_lo);
        mf_d    = out_t'(shifted);
        if (shifted > diff_t'(OUT_MAX)) begin
            mf_d = out_t'(OUT_MAX);
        end else if (shifted < diff_t'(OUT_MIN)) begin
            mf_d = out_t'(OUT_MIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < N_MAX; j++) begin
                x_q[j] <= '0;
                y_q[j] <= '0;
            end
            re_lo_q <= '0;
            im_lo_q <= '0;
            re_hi_q <= '0;
            im_hi_q <= '0;
            mf_q    <= '0;
            dec_q   <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            // Offset binary to signed: flipping the MSB subtracts 8
            x_q[0] <= sample_t'({~mf_bus.I_BPF[W_IN-1], mf_bus.I_BPF[W_IN-2:0]});
            y_q[0] <= sample_t'({~mf_bus.Q_BPF[W_IN-1], mf_bus.Q_BPF[W_IN-2:0]});
            for (int j = 1; j < N_MAX; j++) begin
                x_q[j] <= x_q[j-1];
                y_q[j] <= y_q[j-1];
            end
            re_lo_q <= re_lo_d;
            im_lo_q <= im_lo_d;
            re_hi_q <= re_hi_d;
            im_hi_q <= im_hi_d;
            mf_q    <= mf_d;
            dec_q   <= dec_d;
            if (mf_bus.update) begin
                data_q <= dec_q;
            end
        end
    end

    assign mf_bus.MF_Output = mf_q;
    assign mf_bus.data      = data_q;
endmodule

// File: tb/tb_matched_filter.sv
// Bench for matched_filter: directed tone scenarios plus random I/Q, scored against a
// floating-point correlation model over the sample history.
module tb_matched_filter;
    localparam int  N_MAX = 16;
    localparam real PI    = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matched_filter_if #(.W_IN(4), .W_OUT(8)) mf_if ();

    matched_filter #(.W_IN(4), .W_COEF(4), .N_MAX(N_MAX), .W_OUT(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .mf_bus (mf_if.slave)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    real f_lo_tab [4] = '{2.0, 2.0, 1.5, 1.0};
    real f_hi_tab [4] = '{2.5, 3.0, 2.0, 1.5};
    int  hx[$];
    int  hy[$];
    logic [8:0] exp_q[$];
    logic cur_d;
    bit   cur_valid;
    logic data_exp;
    bit   data_known;
    int   skip;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int energy(input real f, input int n);
        int re;
        int im;
        re = 0;
        im = 0;
        for (int k = 0; k < n; k++) begin
            int  idx;
            real ang;
            int  c;
            int  s;
            idx = N_MAX - n + k;
            ang = 2.0 * PI * f * k / 16.0;
            c   = int'(7.0 * $cos(ang));
            s   = int'(7.0 * $sin(ang));
            re  = re + hx[idx] * c + hy[idx] * s;
            im  = im + hy[idx] * c - hx[idx] * s;
        end
        return iabs(re) + iabs(im);
    endfunction

    function automatic logic [8:0] model_out(input int mode);
        int n;
        int el;
        int eh;
        int m;
        n  = (mode == 1) ? 8 : 16;
        el = energy(f_lo_tab[mode], n);
        eh = energy(f_hi_tab[mode], n);
        m  = (eh - el) >>> 4;
        if (m > 127)  m = 127;
        if (m < -128) m = -128;
        return {(eh > el), 8'(m)};
    endfunction

    task automatic model_reset();
        hx.delete();
        hy.delete();
        for (int i = 0; i < N_MAX; i++) begin
            hx.push_back(0);
            hy.push_back(0);
        end
        exp_q.delete();
        exp_q.push_back(model_out(int'(mf_if.select)));
        exp_q.push_back(model_out(int'(mf_if.select)));
        cur_d      = 1'b0;
        cur_valid  = 1'b1;
        data_exp   = 1'b0;
        data_known = 1'b1;
        skip       = 0;
    endtask

    function automatic int tone_i(input real f, input int n);
        return 8 + int'(7.0 * $cos(2.0 * PI * f * n / 16.0));
    endfunction

    function automatic int tone_q(input real f, input int n);
        return 8 + int'(7.0 * $sin(2.0 * PI * f * n / 16.0));
    endfunction

    // ---------------- drivers ----------------
    // Entered and left on a falling edge; outputs are compared on the falling edge.
    task automatic step(input int i_s, input int q_s, input bit upd);
        logic [8:0] vis;
        mf_if.I_BPF  = 4'(i_s);
        mf_if.Q_BPF  = 4'(q_s);
        mf_if.update = upd;
        @(posedge clk);
        if (upd) begin
            data_exp   = cur_d;
            data_known = cur_valid;
        end
        void'(hx.pop_front());
        void'(hy.pop_front());
        hx.push_back(i_s - 8);
        hy.push_back(q_s - 8);
        exp_q.push_back(model_out(int'(mf_if.select)));
        vis = exp_q.pop_front();
        if (skip > 0) skip--;
        cur_valid = (skip == 0);
        cur_d     = vis[8];
        @(negedge clk);
        if (cur_valid) check("mf_output", $signed(mf_if.MF_Output), $signed(vis[7:0]));
        if (data_known) check("data", mf_if.data, data_exp);
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (m != mf_if.select) skip = N_MAX + 3;
        mf_if.select = m;
    endtask

    task automatic do_reset(input int cycles);
        logic [1:0] sel_keep;
        sel_keep = mf_if.select;
        rst = 1'b0;
        #1;
        check("rst_async_mf", $signed(mf_if.MF_Output), 0);
        check("rst_async_data", mf_if.data, 0);
        for (int c = 0; c < cycles; c++) begin
            mf_if.I_BPF  = 4'($urandom_range(0, 15));
            mf_if.Q_BPF  = 4'($urandom_range(0, 15));
            mf_if.update = 1'($urandom_range(0, 1));
            mf_if.select = 2'($urandom_range(0, 3));
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_mf", $signed(mf_if.MF_Output), 0);
            check("rst_hold_data", mf_if.data, 0);
        end
        mf_if.select = sel_keep;
        mf_if.update = 1'b0;
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic saved_data;

    initial begin
        rst          = 1'b0;
        mf_if.select = 2'd0;
        mf_if.update = 1'b0;
        mf_if.I_BPF  = 4'd8;
        mf_if.Q_BPF  = 4'd8;
        model_reset();
        @(negedge clk);

        // Reset with toggling inputs, then idle I=Q=8 gives a tie -> 0
        do_reset(5);
        for (int t = 0; t < 24; t++) step(8, 8, (t % 6) == 5);
        check("t1_mf_idle", $signed(mf_if.MF_Output), 0);
        check("t1_data_idle", mf_if.data, 0);

        // Mode 0, high tone 2.5 MHz
        for (int t = 0; t < 64; t++) begin
            step(tone_i(2.5, t), tone_q(2.5, t), (t % 16) == 15);
            if (t >= 31 && (t % 16) == 15) check("t2_data_high", mf_if.data, 1);
        end
        check("t2_mf_pos", ($signed(mf_if.MF_Output) > 0) ? 1 : 0, 1);

        // Mode 0, low tone 2.0 MHz
        for (int t = 0; t < 64; t++) begin
            step(tone_i(2.0, t), tone_q(2.0, t), (t % 16) == 15);
            if (t >= 31 && (t % 16) == 15) check("t3_data_low", mf_if.data, 0);
        end
        check("t3_mf_neg", ($signed(mf_if.MF_Output) < 0) ? 1 : 0, 1);

        // Mode 1, alternating 8-sample bursts 3.0/2.0 MHz, strobe 3 after each burst end
        set_mode(2'd1);
        for (int t = 0; t < 88; t++) begin
            step(tone_i((((t / 8) % 2) == 0) ? 3.0 : 2.0, t % 8),
                 tone_q((((t / 8) % 2) == 0) ? 3.0 : 2.0, t % 8),
                 (t >= 10) && ((t % 8) == 2));
            if (t >= 10 && (t % 8) == 2)
                check("t4_burst_bit", mf_if.data, ((((t / 8) - 1) % 2) == 0) ? 1 : 0);
        end

        // Mode 0: settle on the high tone, then hold update low while the tone flips
        set_mode(2'd0);
        for (int t = 0; t < 40; t++) step(tone_i(2.5, t), tone_q(2.5, t), t == 39);
        saved_data = mf_if.data;
        check("t5_data_before", saved_data, 1);
        for (int t = 0; t < 100; t++) begin
            step(tone_i((((t / 25) % 2) == 0) ? 2.0 : 2.5, t),
                 tone_q((((t / 25) % 2) == 0) ? 2.0 : 2.5, t), 1'b0);
            if ((t % 25) == 24) check("t5_data_frozen", mf_if.data, saved_data);
        end

        // Mode 3: low tone, one-cycle reset mid-stream, then high tone resumes after N+3
        set_mode(2'd3);
        for (int t = 0; t < 48; t++) step(tone_i(1.0, t), tone_q(1.0, t), (t % 16) == 15);
        check("t6_data_low", mf_if.data, 0);
        do_reset(1);
        for (int t = 0; t < 20; t++) step(tone_i(1.5, t), tone_q(1.5, t), t == 19);
        check("t6_resume", mf_if.data, 1);

        // Random I/Q, strobes and occasional mode changes
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 99) == 0) set_mode(2'($urandom_range(0, 3)));
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
